fifo_rd_stream_ctrl: RTL and testbench

Read-side drain controller for the asynchronous FIFO, in the R_CLK domain. It watches the FIFO empty flag, issues read increments and captures the combinationally-read word into a 2-entry output buffer. It presents the words to the downstream consumer (UART TX / pulse-gen path) as a registered valid/ready stream. This decouples consumer back-pressure from the FIFO pointer logic.

---
 rtl/fifo_rd_stream_ctrl_pkg.sv | 12 +
 rtl/fifo_rd_stream_ctrl_if.sv | 22 ++
 rtl/fifo_rd_stream_ctrl_skid_buf.sv | 76 +++++++
 rtl/fifo_rd_stream_ctrl.sv | 58 +++++
 tb/tb_fifo_rd_stream_ctrl.sv | 145 ++++++++++++++
 5 files changed

// File: rtl/fifo_rd_stream_ctrl_pkg.sv
// fifo_pkg: shared occupancy encoding and default word width for the FIFO read-side drain path
package fifo_pkg;

   localparam int DATA_WIDTH_DEF = 8;

   typedef enum logic [1:0] {
      CNT_EMPTY = 2'd0,
      CNT_ONE   = 2'd1,
      CNT_FULL  = 2'd2
   } occ_t;

endpackage

// File: rtl/fifo_rd_stream_ctrl_if.sv
// fifo_rd_stream_ctrl_if: valid/ready word stream from the read-side drain controller to its consumer
interface fifo_rd_stream_ctrl_if #(
   parameter int DATA_WIDTH = 8
);

   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_valid;
   logic                  out_ready;

   modport master (
      output out_data,
      output out_valid,
      input  out_ready
   );

   modport slave (
      input  out_data,
      input  out_valid,
      output out_ready
   );

endinterface

// File: rtl/fifo_rd_stream_ctrl_skid_buf.sv
// fifo_rd_skid_buf: 2-entry head/skid output buffer; occupancy is the FSM state, outputs come from registers only
module fifo_rd_skid_buf
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic                  R_CLK,
   input  logic                  R_RST,
   input  logic                  i_push,
   input  logic                  i_ready,
   input  logic                  i_flush,
   input  logic [DATA_WIDTH-1:0] i_data,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_valid,
   output logic                  o_full
);

   occ_t                  r_cnt;
   occ_t                  w_cnt_nxt;
   logic [DATA_WIDTH-1:0] r_head;
   logic [DATA_WIDTH-1:0] r_skid;
   logic [DATA_WIDTH-1:0] w_head_d;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_ld_head;
   logic                  w_ld_skid;

   // a flush cycle neither accepts nor releases a word; FULL can never accept
   assign w_push = i_push & ~i_flush & (r_cnt != CNT_FULL);
   assign w_pop  = (r_cnt != CNT_EMPTY) & i_ready & ~i_flush;

   // occupancy register, cleared asynchronously so buffered words vanish on reset
   always_ff @(posedge R_CLK or negedge R_RST) begin
      if (!R_RST) r_cnt <= CNT_EMPTY;
      else        r_cnt <= w_cnt_nxt;
   end

   // next occupancy from push/pop, flush forces empty
   always_comb begin
      w_cnt_nxt = r_cnt;
      if (i_flush) w_cnt_nxt = CNT_EMPTY;
      else begin
         case (r_cnt)
            CNT_EMPTY: w_cnt_nxt = w_push ? CNT_ONE : CNT_EMPTY;
            CNT_ONE:   w_cnt_nxt = (w_push & ~w_pop) ? CNT_FULL :
                                   (w_pop & ~w_push) ? CNT_EMPTY : CNT_ONE;
            CNT_FULL:  w_cnt_nxt = w_pop ? CNT_ONE : CNT_FULL;
            default:   w_cnt_nxt = CNT_EMPTY;
         endcase
      end
   end

   // load steering: a push lands in head when the post-pop buffer would be empty, else in skid
   always_comb begin
      w_ld_head = (w_push & ((r_cnt == CNT_EMPTY) | ((r_cnt == CNT_ONE) & w_pop))) |
                  ((r_cnt == CNT_FULL) & w_pop);
      w_ld_skid = w_push & (r_cnt == CNT_ONE) & ~w_pop;
      w_head_d  = (r_cnt == CNT_FULL) ? r_skid : i_data;
   end

   // head/skid word registers
   always_ff @(posedge R_CLK or negedge R_RST) begin
      if (!R_RST) begin
         r_head <= '0;
         r_skid <= '0;
      end else begin
         if (w_ld_head) r_head <= w_head_d;
         if (w_ld_skid) r_skid <= i_data;
      end
   end

   assign o_data  = r_head;
   assign o_valid = (r_cnt != CNT_EMPTY);
   assign o_full  = (r_cnt == CNT_FULL);

endmodule

// File: rtl/fifo_rd_stream_ctrl.sv
// fifo_rd_stream_ctrl: drains the async FIFO read side into a registered valid/ready stream.
// Optional FIFO_RD_WORD_CNT_EN adds a 16-bit popped-word counter output.
module fifo_rd_stream_ctrl
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic                  R_CLK,
   input  logic                  R_RST,
   input  logic                  rd_en,
   input  logic                  flush,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data,
   output logic                  R_inc,
   output logic                  busy,
`ifdef FIFO_RD_WORD_CNT_EN
   output logic [15:0]           word_cnt,
`endif
   fifo_rd_stream_ctrl_if.master strm
);

   logic w_full;
   logic w_valid;

   // read increment never depends on out_ready, so consumer stalls cannot loop back into the pointer logic
   assign R_inc = R_RST & rd_en & ~fifo_empty & ~flush & ~w_full;
   assign busy  = R_RST & (w_valid | (~fifo_empty & rd_en));

   fifo_rd_skid_buf #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_buf (
      .R_CLK   (R_CLK),
      .R_RST   (R_RST),
      .i_push  (R_inc),
      .i_ready (strm.out_ready),
      .i_flush (flush),
      .i_data  (fifo_rd_data),
      .o_data  (strm.out_data),
      .o_valid (w_valid),
      .o_full  (w_full)
   );

   assign strm.out_valid = w_valid;

`ifdef FIFO_RD_WORD_CNT_EN
   logic [15:0] r_word_cnt;

   // counts accepted words, wrapping naturally; flush takes priority over a same-cycle pop
   always_ff @(posedge R_CLK or negedge R_RST) begin
      if (!R_RST)                        r_word_cnt <= '0;
      else if (flush)                    r_word_cnt <= '0;
      else if (w_valid & strm.out_ready) r_word_cnt <= r_word_cnt + 16'd1;
   end

   assign word_cnt = r_word_cnt;
`endif

endmodule

// File: tb/tb_fifo_rd_stream_ctrl.sv
// tb_fifo_rd_stream_ctrl: queue-based FIFO source, occupancy/scoreboard model and a decoupled output monitor
module tb_fifo_rd_stream_ctrl;

   logic       R_CLK = 1'b0;
   logic       R_RST;
   logic       rd_en;
   logic       flush;
   logic       fifo_empty;
   logic [7:0] fifo_rd_data;
   logic       R_inc;
   logic       busy;
`ifdef FIFO_RD_WORD_CNT_EN
   logic [15:0] word_cnt;
`endif

   fifo_rd_stream_ctrl_if #(.DATA_WIDTH(8)) strm ();

   fifo_rd_stream_ctrl #(.DATA_WIDTH(8)) dut (
      .R_CLK        (R_CLK),
      .R_RST        (R_RST),
      .rd_en        (rd_en),
      .flush        (flush),
      .fifo_empty   (fifo_empty),
      .fifo_rd_data (fifo_rd_data),
      .R_inc        (R_inc),
      .busy         (busy),
`ifdef FIFO_RD_WORD_CNT_EN
      .word_cnt     (word_cnt),
`endif
      .strm         (strm)
   );

   always #5 R_CLK = ~R_CLK;

   logic [7:0] src[$];
   logic [7:0] exp_q[$];
   int         nvec = 0;
   int         nerr = 0;
   int         npop = 0;
   int         ninc = 0;
   int         wc   = 0;
   int         n0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      nvec++;
      if (act !== req) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // one clock cycle: drive at +1, check control outputs at +3, advance the model at +6
   task automatic cycle(input logic en, input logic fl, input logic rdy, input logic ef, input logic rst);
      @(posedge R_CLK);
      #1;
      R_RST = rst;
      if (!rst) begin
         exp_q.delete();
         wc = 0;
      end
      rd_en          = en;
      flush          = fl;
      strm.out_ready = rdy;
      fifo_empty     = ef | (src.size() == 0);
      fifo_rd_data   = (src.size() != 0) ? src[0] : 8'h5A;
      #2;
      chk("r_inc", R_inc, R_RST & rd_en & ~fifo_empty & ~flush & (exp_q.size() < 2));
      chk("out_valid", strm.out_valid, exp_q.size() != 0);
      chk("busy", busy, R_RST & ((exp_q.size() != 0) | (~fifo_empty & rd_en)));
      if (!R_RST) chk("rst_out_data", strm.out_data, 0);
`ifdef FIFO_RD_WORD_CNT_EN
      chk("word_cnt", word_cnt, wc[15:0]);
`endif
      #3;
      if (flush) begin
         exp_q.delete();
         wc = 0;
      end
      if (R_inc) begin
         exp_q.push_back(fifo_rd_data);
         void'(src.pop_front());
         ninc++;
      end
   endtask

   // monitor: every presented word must be the oldest one still owed to the consumer
   always @(posedge R_CLK) begin
      #4;
      if (strm.out_valid) begin
         if (exp_q.size() == 0) begin
            nvec++;
            nerr++;
            $display("FAIL spurious_valid: got data %0h expected no word at %0t", strm.out_data, $time);
         end else begin
            chk("out_data", strm.out_data, exp_q[0]);
            if (strm.out_ready & ~flush & R_RST) begin
               void'(exp_q.pop_front());
               wc++;
               npop++;
            end
         end
      end
   end

   initial begin
      R_RST = 1'b0; rd_en = 1'b1; flush = 1'b0; fifo_empty = 1'b0;
      fifo_rd_data = 8'hA5; strm.out_ready = 1'b1;
      src.push_back(8'hA5);
      repeat (3) cycle(1, 0, 1, 0, 0);
      cycle(1, 0, 1, 0, 1);
      repeat (3) cycle(1, 0, 1, 0, 1);
      n0 = npop;
      for (int i = 1; i <= 8; i++) src.push_back(8'(i));
      repeat (10) cycle(1, 0, 1, 0, 1);
      chk("stream_pops", npop - n0, 8);
      for (int i = 0; i < 6; i++) src.push_back(8'h30 + 8'(i));
      n0 = ninc;
      repeat (5) cycle(1, 0, 0, 0, 1);
      chk("bp_rinc", ninc - n0, 2);
      repeat (8) cycle(1, 0, 1, 0, 1);
      for (int i = 0; i < 6; i++) src.push_back(8'h60 + 8'(i));
      repeat (3) cycle(1, 0, 0, 0, 1);
      cycle(1, 1, 1, 0, 1);
      repeat (6) cycle(1, 0, 1, 0, 1);
      for (int i = 0; i < 4; i++) src.push_back(8'h70 + 8'(i));
      cycle(1, 0, 1, 0, 1);
      cycle(0, 0, 1, 0, 1);
      cycle(0, 0, 1, 0, 1);
      repeat (4) cycle(1, 0, 1, 0, 1);
      for (int i = 0; i < 8; i++) src.push_back(8'h90 + 8'(i));
      repeat (3) cycle(1, 0, 0, 0, 1);
      cycle(1, 0, 1, 0, 0);
      cycle(1, 0, 1, 0, 0);
      repeat (8) cycle(1, 0, 1, 0, 1);
      for (int n = 0; n < 500; n++) begin
         while (src.size() < 4) src.push_back(8'($urandom));
         cycle($urandom_range(0, 7) != 0, $urandom_range(0, 31) == 0,
               $urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0, 1'b1);
      end
      repeat (4) cycle(0, 0, 1, 1, 1);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
